// File: rtl/gpc_popcount_sched.sv
// rtl/gpc_popcount_sched.sv - sequential popcount engine sharing one gpc6_3 counter across 6-bit chunks
// Operand is latched on acceptance and reduced one chunk per cycle into a registered count.

module gpc6_3 (
    input  logic [5:0] src0,
    output logic [2:0] dst
);
    always_comb begin
        dst = 3'd0;
        for (int i = 0; i < 6; i++) begin
            dst = dst + {2'b00, src0[i]};
        end
    end
endmodule

module gpc_popcount_sched #(
    parameter int WIDTH = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(WIDTH+1)-1:0] out_count,
    output logic                       busy
);
    localparam int NCHUNK = (WIDTH + 5) / 6;
    localparam int SUMW   = $clog2(WIDTH + 1);
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int PADW   = NCHUNK * 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  op_q, op_d;
    logic [SUMW-1:0]   acc_q, acc_d;
    logic [IDXW-1:0]   idx_q, idx_d;

    logic [PADW-1:0]   op_pad;
    logic [5:0]        chunk;
    logic [2:0]        chunk_sum;

    // Upper bits of the last chunk read as zero when WIDTH is not a multiple of 6.
    always_comb begin
        op_pad             = '0;
        op_pad[WIDTH-1:0]  = op_q;
        chunk              = 6'd0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (idx_q == IDXW'(k)) begin
                chunk = op_pad[k*6 +: 6];
            end
        end
    end

    gpc6_3 u_gpc (
        .src0 (chunk),
        .dst  (chunk_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    op_d    = in_data;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_q + SUMW'(chunk_sum);
                if (idx_q == IDXW'(NCHUNK - 1)) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign out_count = acc_q;
endmodule

// File: tb/tb_gpc_popcount_sched.sv
// tb/tb_gpc_popcount_sched.sv - scoreboard bench for gpc_popcount_sched at WIDTH=24 and WIDTH=7
// Drivers push expected counts and acceptance edges; a negedge monitor pops and compares.

module tb_gpc_popcount_sched;
    typedef struct {
        int     cnt;
        longint t;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [1:0]  in_valid, in_ready, out_valid, out_ready, busy;
    logic [23:0] in_data [2];
    logic [4:0]  cnt24;
    logic [2:0]  cnt7;

    longint cyc;
    int     checks, errors;
    exp_t   q0[$], q1[$];
    bit     active [2];
    int     exp_cnt [2];
    bit     rnd_en;

    gpc_popcount_sched #(.WIDTH(24)) u24 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_count(cnt24),
        .busy(busy[0])
    );

    gpc_popcount_sched #(.WIDTH(7)) u7 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1][6:0]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_count(cnt7),
        .busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1ms;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int nch(input int g);
        return (g == 0) ? 4 : 2;
    endfunction

    function automatic int model_count(input int g, input logic [23:0] d);
        logic [23:0] mask;
        mask = (g == 0) ? 24'hFFFFFF : 24'h00007F;
        return $countones(d & mask);
    endfunction

    function automatic int qsize(input int g);
        return (g == 0) ? q0.size() : q1.size();
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: first cycle of out_valid pops the scoreboard; every DONE cycle re-checks the held result.
    initial begin
        exp_t e;
        longint cur;
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                cur = (g == 0) ? longint'(cnt24) : longint'(cnt7);
                if (rst) begin
                    active[g] = 1'b0;
                end else if (out_valid[g]) begin
                    if (!active[g]) begin
                        chk($sformatf("result_expected_%0d", g), qsize(g) > 0, 1);
                        if (qsize(g) > 0) begin
                            if (g == 0) e = q0.pop_front(); else e = q1.pop_front();
                            exp_cnt[g] = e.cnt;
                            chk($sformatf("latency_%0d", g), cyc - e.t, nch(g));
                        end
                        active[g] = 1'b1;
                    end
                    chk($sformatf("count_%0d", g), cur, exp_cnt[g]);
                    chk($sformatf("in_ready_done_%0d", g), in_ready[g], 0);
                    chk($sformatf("busy_done_%0d", g), busy[g], 1);
                    if (out_ready[g]) active[g] = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_en) out_ready[1] = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input int g, input logic [23:0] d, output longint t);
        exp_t e;
        int n;
        in_data[g]  = d;
        in_valid[g] = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready[g] && !rst) break;
            n++;
            if (n > 60) break;
        end
        chk($sformatf("accept_bound_%0d", g), n <= 60, 1);
        t = cyc + 1;
        e.cnt = model_count(g, d);
        e.t   = t;
        if (g == 0) q0.push_back(e); else q1.push_back(e);
        @(posedge clk);
        #1;
        in_valid[g] = 1'b0;
        in_data[g]  = 24'($urandom);
    endtask

    task automatic wait_idle(input int g);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(qsize(g) == 0 && !active[g] && in_ready[g]) && n < 300);
        chk($sformatf("drain_bound_%0d", g), n < 300, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input int g, input string tag);
        chk({tag, "_in_ready"}, in_ready[g], 1);
        chk({tag, "_out_valid"}, out_valid[g], 0);
        chk({tag, "_busy"}, busy[g], 0);
    endtask

    initial begin
        longint t1, t2, t3;
        logic [23:0] vec24 [3];
        checks = 0;
        errors = 0;
        cyc = 0;
        rnd_en = 1'b0;
        rst = 1'b1;
        in_valid = 2'b00;
        out_ready = 2'b11;
        in_data[0] = '0;
        in_data[1] = '0;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk_idle(g, $sformatf("reset_%0d", g));
        end
        chk("reset_count_24", cnt24, 0);
        chk("reset_count_7", cnt7, 0);
        @(posedge clk);
        #1;

        send(0, 24'hFFFFFF, t1);
        wait_idle(0);

        vec24[0] = 24'hA5A5A5;
        vec24[1] = 24'h000000;
        vec24[2] = 24'h800001;
        send(0, vec24[0], t1);
        send(0, vec24[1], t2);
        send(0, vec24[2], t3);
        chk("throughput_a", t2 - t1, 6);
        chk("throughput_b", t3 - t2, 6);
        wait_idle(0);

        out_ready[0] = 1'b0;
        send(0, 24'h123456, t1);
        for (int n = 0; n < 20 && !out_valid[0]; n++) @(negedge clk);
        chk("stall_reached_done", out_valid[0], 1);
        repeat (5) @(negedge clk);
        chk("stall_out_valid", out_valid[0], 1);
        @(posedge clk);
        #1 out_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_idle(0, "release");
        @(posedge clk);
        #1;

        send(0, 24'hFFFFFF, t1);
        @(posedge clk);
        #1 rst = 1'b1;
        q0.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_idle(0, "abort");
        repeat (8) @(negedge clk);
        chk("abort_no_result", out_valid[0], 0);
        @(posedge clk);
        #1;
        send(0, 24'h00000F, t1);
        wait_idle(0);

        send(1, 24'h00007F, t1);
        send(1, 24'h000040, t2);
        chk("throughput_w7", t2 - t1, 4);
        wait_idle(1);

        rnd_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            send(1, 24'($urandom), t1);
        end
        wait_idle(1);
        rnd_en = 1'b0;
        out_ready[1] = 1'b1;
        wait_idle(1);

        for (int i = 0; i < 30; i++) begin
            send(0, 24'($urandom), t1);
        end
        wait_idle(0);

        chk("queue_empty_24", q0.size(), 0);
        chk("queue_empty_7", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
